// File: rtl/debounce_bank.sv
// Multi-channel push-button / switch debouncer: synchroniser, stability filter,
// debounced level with rise/fall pulses, and optional auto-repeat press strobes.
module debounce_bank #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter bit          RESET_LEVEL   = 1'b0,
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = 5000000,
    parameter int unsigned REPEAT_PERIOD = 1000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] press
);

    localparam int unsigned CW   = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    typedef enum logic {PhDelay, PhPeriod} phase_e;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   s;
        logic                   hold_q, hold_d;
        logic [CW-1:0]          cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   rep;

        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], btn_in[g]};
        end

        assign s = sync_q[SYNC_STAGES-1];

        // Any disagreement with the held sample restarts the stability window.
        always_comb begin
            hold_d  = hold_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            if (s != hold_q) begin
                hold_d = s;
                cnt_d  = '0;
            end else begin
                if (cnt_q < CW'(STABLE_CYCLES)) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    level_d = hold_q;
                end
            end
            rise_d = level_d & ~level_q;
            fall_d = ~level_d & level_q;
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
                hold_q  <= RESET_LEVEL;
                cnt_q   <= '0;
                level_q <= RESET_LEVEL;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                hold_q  <= hold_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        if (REPEAT_EN) begin : g_rep
            logic [RW-1:0] rcnt_q, rcnt_d;
            phase_e        phase_q, phase_d;
            logic          rep_q, rep_d;

            // Counter is cleared on the edge that raises level, so the first
            // strobe lands exactly REPEAT_DELAY cycles after the rise pulse.
            always_comb begin
                rcnt_d  = rcnt_q;
                phase_d = phase_q;
                rep_d   = 1'b0;
                if (rise_d) begin
                    rcnt_d  = '0;
                    phase_d = PhDelay;
                end else if (!level_d) begin
                    rcnt_d = '0;
                end else if (((phase_q == PhDelay) && (rcnt_q == RW'(REPEAT_DELAY - 1))) ||
                             ((phase_q == PhPeriod) && (rcnt_q == RW'(REPEAT_PERIOD - 1)))) begin
                    rep_d   = 1'b1;
                    rcnt_d  = '0;
                    phase_d = PhPeriod;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    rcnt_q  <= '0;
                    phase_q <= PhDelay;
                    rep_q   <= 1'b0;
                end else begin
                    rcnt_q  <= rcnt_d;
                    phase_q <= phase_d;
                    rep_q   <= rep_d;
                end
            end

            assign rep = rep_q;
        end else begin : g_norep
            assign rep = 1'b0;
        end

        assign level[g] = level_q;
        assign rise[g]  = rise_q;
        assign fall[g]  = fall_q;
        assign press[g] = rise_q | rep;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed self-checking bench for debounce_bank: clean step, bounce, glitch
// rejection, auto-repeat, asynchronous reset and simultaneous channels.
module tb_debounce_bank;

    logic       clock;
    logic       reset;
    logic [1:0] btn_in;
    logic [1:0] level, rise, fall, press;

    int total;
    int passed;
    int failed;

    debounce_bank #(
        .CHANNELS      (2),
        .STABLE_CYCLES (8),
        .SYNC_STAGES   (2),
        .RESET_LEVEL   (1'b0),
        .REPEAT_EN     (1'b1),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .btn_in (btn_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall),
        .press  (press)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Each step ends on a falling edge, one rising edge later.
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int act;
        total  = 0;
        passed = 0;
        failed = 0;
        reset  = 1'b0;
        btn_in = 2'b00;

        // Reset state
        #12;
        chk("rst_level", level, 2'b00);
        chk("rst_rise", rise, 2'b00);
        chk("rst_fall", fall, 2'b00);
        chk("rst_press", press, 2'b00);
        @(negedge clock);
        reset = 1'b1;
        step(3);

        // 1: clean step on channel 0
        btn_in = 2'b01;
        step(10);
        chk("step_level_early", level, 2'b00);
        step(1);
        chk("step_level", level, 2'b01);
        chk("step_rise", rise, 2'b01);
        chk("step_press", press, 2'b01);
        chk("step_fall", fall, 2'b00);
        step(1);
        chk("step_rise_once", rise, 2'b00);
        chk("step_press_once", press, 2'b00);

        // 4: hold -> repeat strobes at rise+20, +25, +30
        step(18);
        chk("rep_pre20", press, 2'b00);
        step(1);
        chk("rep_20", press, 2'b01);
        step(1);
        chk("rep_21", press, 2'b00);
        step(3);
        chk("rep_24", press, 2'b00);
        step(1);
        chk("rep_25", press, 2'b01);
        step(5);
        chk("rep_30", press, 2'b01);
        btn_in = 2'b00;
        step(5);
        chk("rep_35", press, 2'b01);
        step(5);
        chk("rel_level_early", level, 2'b01);
        step(1);
        chk("rel_fall", fall, 2'b01);
        chk("rel_level", level, 2'b00);
        chk("rel_press", press, 2'b00);
        act = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (press != 2'b00 || fall != 2'b00) act++;
        end
        chk_n("rel_quiet", act, 0);

        // 2: bounce on channel 0, then held high
        act = 0;
        for (int i = 0; i < 10; i++) begin
            btn_in[0] = (i % 2 == 0);
            for (int k = 0; k < 3; k++) begin
                step(1);
                if ((level | rise | fall | press) != 2'b00) act++;
            end
        end
        btn_in[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if ((level | rise | fall | press) != 2'b00) act++;
        end
        chk_n("bounce_quiet", act, 0);
        step(1);
        chk("bounce_rise", rise, 2'b01);
        btn_in = 2'b00;
        step(11);
        chk("bounce_fall", fall, 2'b01);
        step(5);

        // 3: glitch on channel 1 is rejected, longer pulse accepted
        btn_in = 2'b10;
        step(7);
        btn_in = 2'b00;
        act = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if ((level | rise | fall | press) != 2'b00) act++;
        end
        chk_n("glitch_quiet", act, 0);
        btn_in = 2'b10;
        step(9);
        btn_in = 2'b00;
        step(1);
        chk("pulse_level_early", level, 2'b00);
        step(1);
        chk("pulse_rise", rise, 2'b10);
        chk("pulse_press", press, 2'b10);
        step(8);
        chk("pulse_fall_early", fall, 2'b00);
        step(1);
        chk("pulse_fall", fall, 2'b10);
        chk("pulse_level_low", level, 2'b00);
        step(5);

        // 5: async reset while level[0]=1 and a release is being counted
        btn_in = 2'b01;
        step(11);
        chk("rst5_level", level, 2'b01);
        btn_in = 2'b00;
        step(8);
        #2;
        reset = 1'b0;
        #1;
        chk("rst5_level_now", level, 2'b00);
        chk("rst5_pulses_now", rise | fall | press, 2'b00);
        @(negedge clock);
        btn_in = 2'b01;
        reset  = 1'b1;
        step(10);
        chk("rst5_level_early", level, 2'b00);
        step(1);
        chk("rst5_rise", rise, 2'b01);
        btn_in = 2'b00;
        step(11);
        chk("rst5_fall", fall, 2'b01);
        step(5);

        // 6: both channels together
        btn_in = 2'b11;
        step(11);
        chk("both_rise", rise, 2'b11);
        chk("both_press", press, 2'b11);
        btn_in = 2'b00;
        step(10);
        chk("both_level_held", level, 2'b11);
        step(1);
        chk("both_fall", fall, 2'b11);
        chk("both_level_low", level, 2'b00);
        step(1);
        chk("both_fall_once", fall, 2'b00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
